// File: rtl/arb_pkg.sv
// Shared constants, FSM state encoding and the 3-to-8 one-hot decode for rr_arbiter8.
package arb_pkg;

  localparam int N            = 8;
  localparam int IDX_W        = 3;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N-1:0] dec3x8(input logic [IDX_W-1:0] idx);
    dec3x8      = '0;
    dec3x8[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit searching from ptr+1 upward (mod 8),
// optionally ignoring one requester (the current owner).
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]     w_masked;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_off;

  always_comb begin
    w_masked = req & ~(mask_en ? dec3x8(mask_idx) : {N{1'b0}});
    w_base   = ptr + IDX_W'(1);
    w_rot    = '0;
    // w_rot[0] is the highest-priority candidate; index arithmetic wraps at IDX_W bits.
    for (int i = 0; i < N; i++) begin
      w_rot[i] = w_masked[w_base + IDX_W'(i)];
    end
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
    found = |w_rot;
    idx   = w_base + w_off;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others are waiting.
module rr_arbiter8
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
  #(parameter int unsigned MAX_HOLD = MAX_HOLD_DEF)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             dbg_state
);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] w_pick_ptr;
  logic             w_pick_mask_en;
  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_new_grant;
  logic             w_timeout;

  // While granted, search starts just past the owner with the owner masked, so the
  // same pick serves both release hand-off and preemption.
  always_comb begin
    w_pick_mask_en = (r_state == ST_GRANT);
    w_pick_ptr     = w_pick_mask_en ? r_gnt_idx : r_ptr;
  end

  rr_pick u_pick (
    .req      (req),
    .ptr      (w_pick_ptr),
    .mask_idx (r_gnt_idx),
    .mask_en  (w_pick_mask_en),
    .found    (w_found),
    .idx      (w_pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_new_grant) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_GRANT && r_hold_cnt < HOLD_LAST) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_hold_cnt >= HOLD_LAST) && w_found;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_gnt_idx;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en && w_found) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_pick_idx;
          w_new_grant = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          w_ptr_nxt   = r_gnt_idx;
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
        end else if (!req[r_gnt_idx] || w_timeout) begin
          w_ptr_nxt = r_gnt_idx;
          if (w_found) begin
            w_idx_nxt   = w_pick_idx;
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= IDX_W'(N - 1);
      r_gnt_idx <= '0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt_idx <= w_idx_nxt;
      r_gnt     <= (w_state_nxt == ST_GRANT) ? dec3x8(w_idx_nxt) : {N{1'b0}};
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = (r_state == ST_GRANT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, hand sequences, then random traffic
// checked against a rule-level round-robin model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int M_MAX_HOLD = 4;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       dbg_state;

`ifdef ARB_TIMEOUT_EN
  rr_arbiter8 #(.MAX_HOLD(M_MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .dbg_state(dbg_state)
  );
`else
  rr_arbiter8 dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .dbg_state(dbg_state)
  );
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: owner (-1 = none), last owner, hold count
  int m_owner = -1;
  int m_ptr   = 7;
  int m_cnt   = 0;
  logic [11:0] exp_q[$];

  function automatic int search(input int p, input int excl, input logic [7:0] q);
    for (int k = 1; k <= 8; k++) begin
      int j;
      j = (p + k) % 8;
      if (j != excl && q[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] q);
    logic [7:0] g;
    bit preempt;
    preempt = 1'b0;
    if (r) begin
      m_owner = -1; m_ptr = 7; m_cnt = 0;
    end else if (m_owner < 0) begin
      if (e && q != 8'h00) begin
        m_owner = search(m_ptr, -1, q);
        m_cnt   = 0;
      end
    end else if (!e) begin
      m_ptr = m_owner; m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      preempt = (m_cnt >= M_MAX_HOLD - 1) && (search(m_owner, m_owner, q) >= 0);
`endif
      if (!q[m_owner] || preempt) begin
        m_ptr   = m_owner;
        m_owner = search(m_owner, m_owner, q);
        m_cnt   = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
        if (m_cnt < M_MAX_HOLD - 1) m_cnt++;
`endif
      end
    end
    g = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
    exp_q.push_back({(m_owner >= 0), 3'((m_owner < 0) ? 0 : m_owner), g});
  endtask

  // driver: inputs set after an edge, one clock, outputs sampled 1 ns past the edge
  task automatic apply(input logic r, input logic e, input logic [7:0] q);
    rst = r; en = e; req = q;
    model_step(r, e, q);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare DUT outputs with the oldest model prediction
  task automatic check_model(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " model queue empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " gnt"}, int'(gnt), int'(e[7:0]));
    check({tag, " gnt_valid"}, int'(gnt_valid), int'(e[11]));
    check({tag, " dbg_state"}, int'(dbg_state), int'(e[11]));
    if (e[11]) check({tag, " gnt_idx"}, int'(gnt_idx), int'(e[10:8]));
    check({tag, " onehot"}, int'($countones(gnt) <= 1), 1);
  endtask

  task automatic check_exp(input string tag, input logic [7:0] g, input logic [2:0] i);
    check({tag, " gnt"}, int'(gnt), int'(g));
    check({tag, " gnt_valid"}, int'(gnt_valid), int'(g != 8'h00));
    if (g != 8'h00) check({tag, " gnt_idx"}, int'(gnt_idx), int'(i));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [7:0] q,
                     input logic [7:0] g, input logic [2:0] i);
    vec_t v;
    v.rst = r; v.en = e; v.req = q; v.gnt = g; v.idx = i;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] rq;
    rst = 1'b1; en = 1'b0; req = 8'h00;
    #1;

    // reset, then idle with no requests
    add(1, 0, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 8'h00, 8'h00, 0);
    // requester 0 first after reset, no-bubble hand-off to 7
    add(0, 1, 8'h81, 8'h01, 0);
    add(0, 1, 8'h80, 8'h80, 7);
    add(0, 1, 8'h80, 8'h80, 7);
    add(0, 1, 8'h00, 8'h00, 0);
    // park ptr at 3, then full rotation 4..3
    add(0, 1, 8'h08, 8'h08, 3);
    add(0, 1, 8'h00, 8'h00, 0);
    add(0, 1, 8'hFF, 8'h10, 4);
    add(0, 1, 8'hEF, 8'h20, 5);
    add(0, 1, 8'hDF, 8'h40, 6);
    add(0, 1, 8'hBF, 8'h80, 7);
    add(0, 1, 8'h7F, 8'h01, 0);
    add(0, 1, 8'hFE, 8'h02, 1);
    add(0, 1, 8'hFD, 8'h04, 2);
    add(0, 1, 8'hFB, 8'h08, 3);
    add(0, 1, 8'h00, 8'h00, 0);
    // en drop during owner 2, re-enable favours 5
    add(0, 1, 8'h04, 8'h04, 2);
    add(0, 0, 8'h04, 8'h00, 0);
    add(0, 1, 8'h24, 8'h20, 5);
    add(0, 1, 8'h00, 8'h00, 0);
    // reset during owner 6, then 0 wins
    add(0, 1, 8'h40, 8'h40, 6);
    add(1, 1, 8'h40, 8'h00, 0);
    add(0, 1, 8'h41, 8'h01, 0);
    add(0, 1, 8'h41, 8'h01, 0);
    add(0, 1, 8'h40, 8'h40, 6);
    add(0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].req);
      check_exp($sformatf("tbl[%0d]", i), tbl[i].gnt, tbl[i].idx);
      check_model($sformatf("tbl[%0d] model", i));
    end

    // owner 1 holds with requester 3 waiting
    apply(1, 0, 8'h00); check_model("hold rst");
    apply(0, 1, 8'h0A); check_exp("hold grant1", 8'h02, 1); check_model("hold grant1 model");
    for (int i = 1; i <= 3; i++) begin
      apply(0, 1, 8'h0A);
      check_exp($sformatf("hold c%0d", i), 8'h02, 1);
      check_model($sformatf("hold c%0d model", i));
    end
    apply(0, 1, 8'h0A);
`ifdef ARB_TIMEOUT_EN
    check_exp("hold c4 preempt", 8'h08, 3);
`else
    check_exp("hold c4 keep", 8'h02, 1);
`endif
    check_model("hold c4 model");

    // lone owner 1 keeps the grant; non-owner bit changes ignored in the default build
    apply(1, 0, 8'h00); check_model("solo rst");
    apply(0, 1, 8'h02); check_exp("solo grant", 8'h02, 1); check_model("solo grant model");
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 8'h02);
      check_exp($sformatf("solo c%0d", i), 8'h02, 1);
      check_model($sformatf("solo c%0d model", i));
    end
`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      rq = 8'($urandom_range(0, 255)) | 8'h02;
      apply(0, 1, rq);
      check_exp($sformatf("noise c%0d", i), 8'h02, 1);
      check_model($sformatf("noise c%0d model", i));
    end
`endif

    // random traffic against the model
    rq = 8'h00;
    for (int i = 0; i < 400; i++) begin
      logic r, e;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 0) rq = 8'($urandom_range(0, 255));
      else if ($urandom_range(0, 3) == 0) rq = rq ^ 8'(1 << $urandom_range(0, 7));
      apply(r, e, rq);
      check_model($sformatf("rand[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
